// File: rtl/safe_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter with registered active-low 7-segment outputs.
// Display outputs change only when a conversion completes, so the segment pattern never glitches.
module safe_bcd_display #(
  parameter int WIDTH    = 9,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   hex_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
  localparam longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1;

  if (DEC_RANGE <= MAX_VAL) begin : g_range_check
    $error("safe_bcd_display: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       shift_reg;
  logic [WIDTH-1:0]       pend_value;
  logic                   pend_valid;
  logic [4*DIGITS-1:0]    bcd;
  logic [4*DIGITS-1:0]    bcd_adj;
  logic [CW-1:0]          cnt;
  logic [7*DIGITS-1:0]    hex_enc;
  logic                   lead;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the most-significant digit down; blanking stops at the first non-zero digit.
  always_comb begin
    hex_enc = '1;
    lead    = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (bcd[4*(DIGITS-1-j) +: 4] != 4'd0 || j == DIGITS - 1) lead = 1'b0;
      if (BLANK_LZ != 0 && lead) hex_enc[7*(DIGITS-1-j) +: 7] = 7'h7F;
      else                       hex_enc[7*(DIGITS-1-j) +: 7] = seg7(bcd[4*(DIGITS-1-j) +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      hex_out    <= '1;
      pend_valid <= 1'b0;
      pend_value <= '0;
      shift_reg  <= '0;
      bcd        <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= value;
            bcd       <= '0;
            cnt       <= CW'(WIDTH);
            state     <= SHIFT;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          {bcd, shift_reg} <= {bcd_adj[4*DIGITS-2:0], shift_reg, 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= WRITE;
          if (load) begin
            pend_value <= value;
            pend_valid <= 1'b1;
          end
        end
        WRITE: begin
          hex_out    <= hex_enc;
          done       <= 1'b1;
          pend_valid <= 1'b0;
          // A load on this edge takes priority over (and discards) the pending value.
          if (load || pend_valid) begin
            shift_reg <= load ? value : pend_value;
            bcd       <= '0;
            cnt       <= CW'(WIDTH);
            state     <= SHIFT;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_safe_bcd_display.sv
// Bench for safe_bcd_display: transaction-level timeline model checked every cycle,
// directed scenarios with literal segment patterns, full 0..511 sweep and random loads.
module tb_safe_bcd_display;

  localparam int W = 9;
  localparam int D = 3;
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load = 1'b0;
  logic [W-1:0]    value = '0;
  logic            busy, done, busy_lz, done_lz;
  logic [7*D-1:0]  hex_out, hex_lz;

  int n_checks = 0;
  int n_fail   = 0;

  safe_bcd_display #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .busy(busy), .done(done), .hex_out(hex_out));

  safe_bcd_display #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .busy(busy_lz), .done(done_lz), .hex_out(hex_lz));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7*D-1:0] enc(input int v, input bit blz);
    logic [7*D-1:0] r;
    int p;
    r = '1;
    p = 1;
    for (int k = 0; k < D; k++) begin
      if (blz && k > 0 && v < p) r[7*k +: 7] = 7'h7F;
      else                       r[7*k +: 7] = SEG[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Model: a job finishes WIDTH+1 edges after it is accepted; loads during a job
  // overwrite a single pending slot; at completion a coincident load beats pending.
  int             m_cycle = 0;
  bit             m_active = 0;
  int             m_cur = 0;
  int             m_end = 0;
  bit             m_pv = 0;
  int             m_pval = 0;
  logic [7*D-1:0] exp_hex = '1;
  logic [7*D-1:0] exp_hex_lz = '1;
  bit             exp_done = 0;
  bit             exp_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_pv = 0; exp_hex = '1; exp_hex_lz = '1;
      exp_done = 0; exp_busy = 0;
    end else begin
      m_cycle++;
      exp_done = 0;
      if (m_active && m_cycle == m_end) begin
        exp_hex    = enc(m_cur, 0);
        exp_hex_lz = enc(m_cur, 1);
        exp_done   = 1;
        if (load)      begin m_cur = int'(value); m_end = m_cycle + W + 1; end
        else if (m_pv) begin m_cur = m_pval;      m_end = m_cycle + W + 1; end
        else m_active = 0;
        m_pv = 0;
      end else if (m_active) begin
        if (load) begin m_pv = 1; m_pval = int'(value); end
      end else if (load) begin
        m_active = 1; m_cur = int'(value); m_end = m_cycle + W + 1;
      end
      exp_busy = m_active;
    end
  end

  always @(negedge clk) begin
    chk("hex", 64'(hex_out), 64'(exp_hex));
    chk("done", 64'(done), 64'(exp_done));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("hex_lz", 64'(hex_lz), 64'(exp_hex_lz));
    chk("done_lz", 64'(done_lz), 64'(exp_done));
    chk("busy_lz", 64'(busy_lz), 64'(exp_busy));
  end

  task automatic run_one(input int v, input logic [7*D-1:0] e0, input logic [7*D-1:0] e1,
                         input string nm);
    int n;
    @(negedge clk); load = 1'b1; value = W'(v);
    @(negedge clk); load = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 64'(n), 64'(W + 1));
    chk({nm, "_hex"}, 64'(hex_out), 64'(e0));
    chk({nm, "_hex_lz"}, 64'(hex_lz), 64'(e1));
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    chk({nm, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic sweep_one(input int v);
    int n;
    @(negedge clk); load = 1'b1; value = W'(v);
    @(negedge clk); load = 1'b0;
    n = 0;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("sweep_latency", 64'(n), 64'(W + 1));
  endtask

  initial begin
    int dcount, n;
    bit gap;
    logic [7*D-1:0] first_hex, second_hex;

    repeat (2) @(negedge clk);
    chk("reset_hex", 64'(hex_out), 64'h1FFFFF);
    chk("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_hex", 64'(hex_out), 64'h1FFFFF);
    chk("idle_done", 64'(done), 64'd0);

    run_one(0,   {7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h40}, "v0");
    run_one(511, {7'h12, 7'h79, 7'h79}, {7'h12, 7'h79, 7'h79}, "v511");
    run_one(255, {7'h24, 7'h12, 7'h12}, {7'h24, 7'h12, 7'h12}, "v255");
    run_one(9,   {7'h40, 7'h40, 7'h10}, {7'h7F, 7'h7F, 7'h10}, "v9");
    run_one(7,   {7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h78}, "v7");
    run_one(40,  {7'h40, 7'h19, 7'h40}, {7'h7F, 7'h19, 7'h40}, "v40");

    // Back-to-back: 123 then pending 45 overwritten by 67.
    @(negedge clk); load = 1'b1; value = W'(123);
    @(posedge clk);
    dcount = 0; gap = 0; first_hex = '0; second_hex = '0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      load  = (i == 3 || i == 5);
      value = (i == 3) ? W'(45) : W'(67);
      @(posedge clk); #1;
      if (done) begin
        dcount++;
        if (dcount == 1) first_hex = hex_out; else second_hex = hex_out;
      end
      if (dcount < 2 && !busy) gap = 1;
    end
    load = 1'b0;
    chk("b2b_dones", 64'(dcount), 64'd2);
    chk("b2b_first", 64'(first_hex), 64'({7'h79, 7'h24, 7'h30}));
    chk("b2b_second", 64'(second_hex), 64'({7'h40, 7'h02, 7'h78}));
    chk("b2b_busy_gap", 64'(gap), 64'd0);

    // Reset mid-conversion.
    @(negedge clk); load = 1'b1; value = W'(300);
    @(negedge clk); load = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_hex", 64'(hex_out), 64'h1FFFFF);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
      if (i == 2) rst_n = 1'b1;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run_one(7, {7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h78}, "after_abort");

    for (int v = 0; v < 512; v++) sweep_one(v);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 3) == 0);
      value = W'($urandom_range(0, 511));
    end
    @(negedge clk); load = 1'b0;
    n = 0;
    while ((busy || done) && n < 50) begin @(negedge clk); n++; end
    chk("drain_timeout", 64'(n < 50), 64'd1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
